// File: rtl/idma_inst64_snitch_decoder.sv
// idma_inst64_snitch_decoder: decodes offloaded Snitch DMA instructions into iDMA backend requests
// and answers copy/status instructions with transfer IDs and counter values.
module idma_inst64_snitch_decoder #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned TfIdWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 acc_qvalid_i,
    output logic                 acc_qready_o,
    input  logic [31:0]          acc_qdata_op_i,
    input  logic [DataWidth-1:0] acc_qdata_arga_i,
    input  logic [DataWidth-1:0] acc_qdata_argb_i,
    input  logic [IdWidth-1:0]   acc_qid_i,
    output logic                 acc_pvalid_o,
    input  logic                 acc_pready_i,
    output logic [DataWidth-1:0] acc_pdata_o,
    output logic [IdWidth-1:0]   acc_pid_o,
    output logic                 acc_perror_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [AddrWidth-1:0] req_src_o,
    output logic [AddrWidth-1:0] req_dst_o,
    output logic [DataWidth-1:0] req_len_o,
    output logic [DataWidth-1:0] req_src_stride_o,
    output logic [DataWidth-1:0] req_dst_stride_o,
    output logic [DataWidth-1:0] req_reps_o,
    output logic [4:0]           req_cfg_o,
    input  logic                 tf_done_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e                   state, state_next;
    logic                     accept, legal, is_copy, is_stat;
    logic [6:0]               funct7;
    logic [1:0]               sel;
    logic [4:0]               copy_cfg;
    logic [DataWidth-1:0]     stat_val;
    logic [2*DataWidth-1:0]   addr_arg;
    logic [TfIdWidth-1:0]     next_id, done_cnt;

    always_comb begin
        funct7   = acc_qdata_op_i[31:25];
        legal    = acc_qdata_op_i[6:0] == 7'b0101011 && acc_qdata_op_i[14:12] == 3'b000 && funct7 < 7'd8;
        is_copy  = legal && (funct7 == 7'd2 || funct7 == 7'd3);
        is_stat  = legal && (funct7 == 7'd4 || funct7 == 7'd5);
        accept   = acc_qvalid_i && state == IDLE;
        addr_arg = {acc_qdata_argb_i, acc_qdata_arga_i};
        copy_cfg = funct7[0] ? acc_qdata_argb_i[4:0] : acc_qdata_op_i[24:20];
        sel      = funct7[0] ? acc_qdata_argb_i[1:0] : acc_qdata_op_i[21:20];
        // selector 3 (request pending) is always 0 because status is only accepted in IDLE
        stat_val = sel == 2'd0 ? DataWidth'(done_cnt) :
                   sel == 2'd1 ? DataWidth'(next_id) :
                   sel == 2'd2 ? DataWidth'(next_id != done_cnt) : '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = is_copy ? ISSUE : (!legal || is_stat) ? RESP : IDLE;
            ISSUE:   if (req_ready_i) state_next = RESP;
            RESP:    if (acc_pready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    assign acc_qready_o = state == IDLE;
    assign req_valid_o  = state == ISSUE;
    assign acc_pvalid_o = state == RESP;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_src_o        <= '0;
            req_dst_o        <= '0;
            req_len_o        <= '0;
            req_cfg_o        <= '0;
            req_src_stride_o <= '0;
            req_dst_stride_o <= '0;
            req_reps_o       <= '0;
            next_id          <= '0;
            done_cnt         <= '0;
            acc_pdata_o      <= '0;
            acc_pid_o        <= '0;
            acc_perror_o     <= 1'b0;
        end else begin
            if (tf_done_i && done_cnt != next_id) done_cnt <= done_cnt + TfIdWidth'(1);
            if (accept) begin
                if (legal && funct7 == 7'd0) req_src_o <= addr_arg[AddrWidth-1:0];
                if (legal && funct7 == 7'd1) req_dst_o <= addr_arg[AddrWidth-1:0];
                if (legal && funct7 == 7'd6) begin
                    req_src_stride_o <= acc_qdata_arga_i;
                    req_dst_stride_o <= acc_qdata_argb_i;
                end
                if (legal && funct7 == 7'd7) req_reps_o <= acc_qdata_arga_i;
                if (is_copy) begin
                    req_len_o   <= acc_qdata_arga_i;
                    req_cfg_o   <= copy_cfg;
                    next_id     <= next_id + TfIdWidth'(1);
                    acc_pdata_o <= DataWidth'(next_id);
                end
                if (is_stat) acc_pdata_o <= stat_val;
                if (!legal) acc_pdata_o <= '0;
                if (is_copy || is_stat || !legal) begin
                    acc_pid_o    <= acc_qid_i;
                    acc_perror_o <= !legal;
                end
            end
        end
    end
endmodule

// File: tb/tb_idma_inst64_snitch_decoder.sv
// tb_idma_inst64_snitch_decoder: directed stimulus with a queue-based scoreboard for responses
// and backend requests; a negedge monitor pops and compares on each handshake.
module tb_idma_inst64_snitch_decoder;
    logic        clk = 0, rst_n = 0;
    logic        qvalid = 0, pready = 1, req_ready = 1, tf_done = 0;
    logic [31:0] qop = 0, qa = 0, qb = 0;
    logic [4:0]  qid = 0;
    logic        qready, pvalid, perror, req_valid;
    logic [31:0] pdata, req_len, req_ss, req_ds, req_reps;
    logic [4:0]  pid, req_cfg;
    logic [47:0] req_src, req_dst;
    int          total = 0, passed = 0;

    typedef struct {logic [31:0] d; logic [4:0] id; logic e;} resp_t;
    typedef struct {logic [47:0] src, dst; logic [31:0] len, ss, ds, reps; logic [4:0] cfg;} req_t;
    resp_t rq[$];
    req_t  bq[$];

    idma_inst64_snitch_decoder dut (
        .clk_i(clk), .rst_ni(rst_n),
        .acc_qvalid_i(qvalid), .acc_qready_o(qready), .acc_qdata_op_i(qop),
        .acc_qdata_arga_i(qa), .acc_qdata_argb_i(qb), .acc_qid_i(qid),
        .acc_pvalid_o(pvalid), .acc_pready_i(pready), .acc_pdata_o(pdata),
        .acc_pid_o(pid), .acc_perror_o(perror),
        .req_valid_o(req_valid), .req_ready_i(req_ready),
        .req_src_o(req_src), .req_dst_o(req_dst), .req_len_o(req_len),
        .req_src_stride_o(req_ss), .req_dst_stride_o(req_ds), .req_reps_o(req_reps),
        .req_cfg_o(req_cfg), .tf_done_i(tf_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] imm, input logic [2:0] f3);
        return {f7, imm, 5'd0, f3, 5'd0, 7'b0101011};
    endfunction

    task automatic exp_resp(input logic [31:0] d, input logic [4:0] id, input logic e);
        resp_t r;
        r.d = d; r.id = id; r.e = e;
        rq.push_back(r);
    endtask

    task automatic exp_req(input logic [47:0] src, dst, input logic [31:0] len, input logic [4:0] cfg,
                           input logic [31:0] ss, ds, reps);
        req_t r;
        r.src = src; r.dst = dst; r.len = len; r.cfg = cfg; r.ss = ss; r.ds = ds; r.reps = reps;
        bq.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst_n && pvalid && pready) begin
            if (rq.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
                resp_t r;
                r = rq.pop_front();
                chk("resp_data", pdata, r.d);
                chk("resp_id", pid, r.id);
                chk("resp_err", perror, r.e);
            end
        end
        if (rst_n && req_valid && req_ready) begin
            if (bq.size() == 0) chk("unexpected_req", 1, 0);
            else begin
                req_t r;
                r = bq.pop_front();
                chk("req_src", req_src, r.src);
                chk("req_dst", req_dst, r.dst);
                chk("req_len", req_len, r.len);
                chk("req_cfg", req_cfg, r.cfg);
                chk("req_src_stride", req_ss, r.ss);
                chk("req_dst_stride", req_ds, r.ds);
                chk("req_reps", req_reps, r.reps);
            end
        end
    end

    task automatic issue(input logic [31:0] op, a, b, input logic [4:0] id);
        int n = 0;
        qop = op; qa = a; qb = b; qid = id; qvalid = 1;
        forever begin
            @(negedge clk);
            if (qready) break;
            if (++n > 100) begin
                chk("issue_timeout", 1, 0);
                qvalid = 0;
                return;
            end
        end
        @(posedge clk); #1;
        qvalid = 0;
    endtask

    task automatic pulse_done();
        tf_done = 1;
        @(posedge clk); #1;
        tf_done = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", n < 100, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_qready", qready, 1);
        chk("rst_pvalid", pvalid, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_pdata", pdata, 0);
        chk("rst_src", req_src, 0);
        chk("rst_reps", req_reps, 0);
        @(posedge clk); #1;

        // src/dst packing and a basic copy
        issue(mk(7'd0, 0, 0), 32'h1000, 32'h2, 5'd1);
        issue(mk(7'd1, 0, 0), 32'h3000, 32'h0, 5'd2);
        exp_req(48'h2_0000_1000, 48'h3000, 64, 5'd3, 0, 0, 0);
        exp_resp(0, 5'd5, 0);
        issue(mk(7'd3, 0, 0), 64, 32'h3, 5'd5);
        @(negedge clk);
        chk("copy_req_latency", req_valid, 1);
        drain();

        // backpressured immediate copies after a fresh reset
        do_reset();
        req_ready = 0;
        exp_req(0, 0, 32, 5'd5, 0, 0, 0);
        exp_resp(0, 5'd7, 0);
        issue(mk(7'd2, 5'd5, 0), 32, 0, 5'd7);
        repeat (5) begin
            @(negedge clk);
            chk("hold_req_valid", req_valid, 1);
            chk("hold_qready", qready, 0);
            chk("hold_len", req_len, 32);
            chk("hold_cfg", req_cfg, 5);
        end
        @(posedge clk); #1 req_ready = 1;
        exp_req(0, 0, 16, 5'd6, 0, 0, 0);
        exp_resp(1, 5'd8, 0);
        issue(mk(7'd2, 5'd6, 0), 16, 0, 5'd8);
        drain();

        // status: next_id=2, done=0
        exp_resp(1, 5'd11, 0);
        issue(mk(7'd4, 5'd2, 0), 0, 0, 5'd11);
        pulse_done();
        pulse_done();
        exp_resp(2, 5'd12, 0);
        issue(mk(7'd5, 0, 0), 0, 0, 5'd12);
        exp_resp(0, 5'd13, 0);
        issue(mk(7'd5, 0, 0), 0, 2, 5'd13);
        pulse_done();
        exp_resp(2, 5'd14, 0);
        issue(mk(7'd4, 5'd0, 0), 0, 0, 5'd14);
        exp_resp(2, 5'd15, 0);
        issue(mk(7'd4, 5'd1, 0), 0, 0, 5'd15);
        exp_resp(0, 5'd16, 0);
        issue(mk(7'd5, 0, 0), 0, 3, 5'd16);
        drain();

        // strides and repetitions carried on the request
        issue(mk(7'd6, 0, 0), 8, 16, 5'd1);
        issue(mk(7'd7, 0, 0), 4, 0, 5'd1);
        exp_req(0, 0, 128, 5'd0, 8, 16, 4);
        exp_resp(2, 5'd3, 0);
        issue(mk(7'd3, 0, 0), 128, 0, 5'd3);
        drain();

        // illegal encodings
        exp_resp(0, 5'd9, 1);
        issue(mk(7'd3, 0, 3'b001), 64, 0, 5'd9);
        exp_resp(0, 5'd10, 1);
        issue(mk(7'd9, 0, 0), 64, 0, 5'd10);
        drain();

        // response held, then asynchronous reset drops it
        pready = 0;
        issue(mk(7'd4, 5'd1, 0), 0, 0, 5'd4);
        repeat (4) begin
            @(negedge clk);
            chk("pheld_valid", pvalid, 1);
            chk("pheld_data", pdata, 3);
            chk("pheld_id", pid, 4);
        end
        #2 rst_n = 0;
        #1;
        chk("async_pvalid", pvalid, 0);
        chk("async_pdata", pdata, 0);
        chk("async_pid", pid, 0);
        chk("async_qready", qready, 1);
        chk("async_stride", req_ss, 0);
        chk("async_reps", req_reps, 0);
        @(posedge clk); #1 rst_n = 1;
        pready = 1;
        exp_resp(0, 5'd2, 0);
        issue(mk(7'd4, 5'd1, 0), 0, 0, 5'd2);
        drain();
        chk("resp_queue_empty", rq.size(), 0);
        chk("req_queue_empty", bq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
